// File: rtl/sop_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sop_pkg
// Description : Shared literal codes, FSM state encoding and literal helper
//               for the sum-of-products cover evaluator.
// Revision    : 1.0 - initial release
// ============================================================================
package sop_pkg;

    // Two-bit literal codes carried per input in a cube row
    localparam logic [1:0] LIT_DC   = 2'b00;  // '-' don't care
    localparam logic [1:0] LIT_ONE  = 2'b01;  // input must be 1
    localparam logic [1:0] LIT_ZERO = 2'b10;  // input must be 0
    localparam logic [1:0] LIT_VOID = 2'b11;  // malformed literal, never matches

    // Evaluator FSM encoding
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_EVAL = 2'b01,
        ST_DONE = 2'b10
    } state_e;

    // Does a single literal accept the given input value
    function automatic logic lit_ok(input logic [1:0] lit, input logic v);
        logic ok;
        case (lit)
            LIT_DC:   ok = 1'b1;
            LIT_ONE:  ok = v;
            LIT_ZERO: ok = ~v;
            default:  ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sop_cube_match.sv
`default_nettype none
// ============================================================================
// Module      : sop_cube_match
// Description : Combinational match of one cube row against an input vector.
//               match is the AND of all literals; void_seen flags any void
//               literal in the row.
// Revision    : 1.0 - initial release
// ============================================================================
module sop_cube_match
    import sop_pkg::*;
#(
    parameter int N_IN = 8
) (
    input  logic [N_IN-1:0]   vec,
    input  logic [2*N_IN-1:0] cube,
    output logic              match,
    output logic              void_seen
);

    // AND every literal and OR-reduce the void flags across the row
    always_comb begin
        match     = 1'b1;
        void_seen = 1'b0;
        for (int i = 0; i < N_IN; i++) begin
            if (!lit_ok(cube[2*i +: 2], vec[i])) begin
                match = 1'b0;
            end
            if (cube[2*i +: 2] == LIT_VOID) begin
                void_seen = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/sop_cover_eval.sv
`default_nettype none
// ============================================================================
// Module      : sop_cover_eval
// Description : Streams cube rows of a single-output SOP cover, ORs matching
//               cubes against a latched input vector and returns the net
//               value with ON-set / OFF-set polarity applied.
//               Optional macro SOP_HIT_COUNT_EN enables a saturating count of
//               matching cubes on res_hits (tied to 0 when undefined).
// Revision    : 1.0 - initial release
// ============================================================================
module sop_cover_eval
    import sop_pkg::*;
#(
    parameter int N_IN  = 8,
    parameter int CNT_W = 8
) (
    input  logic              clk,
    input  logic              rst,          // asynchronous, active low
    input  logic              start_valid,
    output logic              start_ready,
    input  logic [N_IN-1:0]   start_vec,
    input  logic              start_pol,
    input  logic              start_empty,
    input  logic              cube_valid,
    output logic              cube_ready,
    input  logic [2*N_IN-1:0] cube_data,
    input  logic              cube_last,
    output logic              res_valid,
    input  logic              res_ready,
    output logic              res_value,
    output logic              res_err,
    output logic [CNT_W-1:0]  res_hits
);

    state_e            state_q, state_d;
    logic [N_IN-1:0]   vec_q, vec_d;
    logic              pol_q, pol_d;
    logic              acc_q, acc_d;
    logic              err_q, err_d;
    logic              res_value_q, res_value_d;

    logic              w_match;
    logic              w_void;
    logic              w_acc_any;
    logic              w_start_fire;
    logic              w_cube_fire;

    // Cube row is always matched against the latched vector
    sop_cube_match #(
        .N_IN (N_IN)
    ) u_cube_match (
        .vec       (vec_q),
        .cube      (cube_data),
        .match     (w_match),
        .void_seen (w_void)
    );

    // Handshake qualifiers and running OR including the current row
    always_comb begin
        w_start_fire = (state_q == ST_IDLE) && start_valid;
        w_cube_fire  = (state_q == ST_EVAL) && cube_valid;
        w_acc_any    = acc_q | w_match;
    end

    // Next-state and datapath update; all values hold by default
    always_comb begin
        state_d     = state_q;
        vec_d       = vec_q;
        pol_d       = pol_q;
        acc_d       = acc_q;
        err_d       = err_q;
        res_value_d = res_value_q;
        case (state_q)
            ST_IDLE: begin
                if (start_valid) begin
                    vec_d       = start_vec;
                    pol_d       = start_pol;
                    acc_d       = 1'b0;
                    err_d       = 1'b0;
                    res_value_d = 1'b0;
                    // An empty cover is constant 0 whatever the polarity
                    state_d     = start_empty ? ST_DONE : ST_EVAL;
                end
            end
            ST_EVAL: begin
                if (cube_valid) begin
                    acc_d = w_acc_any;
                    err_d = err_q | w_void;
                    if (cube_last) begin
                        res_value_d = pol_q ? w_acc_any : ~w_acc_any;
                        state_d     = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                if (res_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            vec_q       <= '0;
            pol_q       <= 1'b0;
            acc_q       <= 1'b0;
            err_q       <= 1'b0;
            res_value_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            vec_q       <= vec_d;
            pol_q       <= pol_d;
            acc_q       <= acc_d;
            err_q       <= err_d;
            res_value_q <= res_value_d;
        end
    end

`ifdef SOP_HIT_COUNT_EN
    localparam logic [CNT_W-1:0] C_HITS_MAX = {CNT_W{1'b1}};

    logic [CNT_W-1:0] hits_q, hits_d;

    // Saturating count of matching rows, cleared when a new cover starts
    always_comb begin
        hits_d = hits_q;
        if (w_start_fire) begin
            hits_d = '0;
        end else if (w_cube_fire && w_match && (hits_q != C_HITS_MAX)) begin
            hits_d = hits_q + CNT_W'(1);
        end
    end

    // Hit counter register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hits_q <= '0;
        end else begin
            hits_q <= hits_d;
        end
    end

    assign res_hits = hits_q;
`else
    assign res_hits = '0;
`endif

    // Handshake and result outputs come straight from registers
    assign start_ready = (state_q == ST_IDLE);
    assign cube_ready  = (state_q == ST_EVAL);
    assign res_valid   = (state_q == ST_DONE);
    assign res_value   = res_value_q;
    assign res_err     = err_q;

endmodule
`default_nettype wire

// File: tb/tb_sop_cover_eval.sv
`default_nettype none
// ============================================================================
// Module      : tb_sop_cover_eval
// Description : Directed self-checking bench for sop_cover_eval (N_IN=4).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sop_cover_eval;

    localparam int N_IN  = 4;
    localparam int CNT_W = 8;
`ifdef SOP_HIT_COUNT_EN
    localparam bit HITS_ON = 1'b1;
`else
    localparam bit HITS_ON = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst;
    logic              start_valid;
    logic              start_ready;
    logic [N_IN-1:0]   start_vec;
    logic              start_pol;
    logic              start_empty;
    logic              cube_valid;
    logic              cube_ready;
    logic [2*N_IN-1:0] cube_data;
    logic              cube_last;
    logic              res_valid;
    logic              res_ready;
    logic              res_value;
    logic              res_err;
    logic [CNT_W-1:0]  res_hits;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    sop_cover_eval #(
        .N_IN  (N_IN),
        .CNT_W (CNT_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start_valid (start_valid),
        .start_ready (start_ready),
        .start_vec   (start_vec),
        .start_pol   (start_pol),
        .start_empty (start_empty),
        .cube_valid  (cube_valid),
        .cube_ready  (cube_ready),
        .cube_data   (cube_data),
        .cube_last   (cube_last),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .res_value   (res_value),
        .res_err     (res_err),
        .res_hits    (res_hits)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] eh(input int h);
        return HITS_ON ? 32'(h) : 32'd0;
    endfunction

    task automatic do_start(input logic [N_IN-1:0] v, input logic p, input logic e);
        @(negedge clk);
        chk("start_ready_idle", 32'(start_ready), 32'd1);
        start_valid = 1'b1;
        start_vec   = v;
        start_pol   = p;
        start_empty = e;
        @(posedge clk);
        #1;
        start_valid = 1'b0;
        start_empty = 1'b0;
    endtask

    task automatic do_cube(input logic [2*N_IN-1:0] d, input logic l);
        @(negedge clk);
        chk("cube_ready_eval", 32'(cube_ready), 32'd1);
        cube_valid = 1'b1;
        cube_data  = d;
        cube_last  = l;
        @(posedge clk);
        #1;
        cube_valid = 1'b0;
        cube_last  = 1'b0;
    endtask

    task automatic check_res(input string tag, input logic v, input logic e, input int h);
        chk({tag, "_valid"}, 32'(res_valid), 32'd1);
        chk({tag, "_value"}, 32'(res_value), 32'(v));
        chk({tag, "_err"},   32'(res_err),   32'(e));
        chk({tag, "_hits"},  32'(res_hits),  eh(h));
    endtask

    task automatic consume(input string tag);
        @(negedge clk);
        res_ready = 1'b1;
        @(posedge clk);
        #1;
        res_ready = 1'b0;
        chk({tag, "_valid_drop"}, 32'(res_valid), 32'd0);
        chk({tag, "_idle"},       32'(start_ready), 32'd1);
    endtask

    initial begin
        rst         = 1'b0;
        start_valid = 1'b0;
        start_vec   = '0;
        start_pol   = 1'b0;
        start_empty = 1'b0;
        cube_valid  = 1'b0;
        cube_data   = '0;
        cube_last   = 1'b0;
        res_ready   = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_start_ready", 32'(start_ready), 32'd1);
        chk("rst_cube_ready",  32'(cube_ready),  32'd0);
        chk("rst_res_valid",   32'(res_valid),   32'd0);
        chk("rst_res_value",   32'(res_value),   32'd0);
        chk("rst_res_err",     32'(res_err),     32'd0);
        chk("rst_res_hits",    32'(res_hits),    32'd0);
        @(negedge clk);
        rst = 1'b1;

        // ON-set, single cube in0='1' in2='1' against vec 0101 -> 1
        do_start(4'b0101, 1'b1, 1'b0);
        do_cube(8'h11, 1'b1);
        check_res("t1", 1'b1, 1'b0, 1);
        consume("t1");

        // Same cover, OFF-set polarity -> 0
        do_start(4'b0101, 1'b0, 1'b0);
        do_cube(8'h11, 1'b1);
        check_res("t2", 1'b0, 1'b0, 1);
        consume("t2");

        // Two cubes, second one matches vec 0000
        do_start(4'b0000, 1'b1, 1'b0);
        do_cube(8'h01, 1'b0);
        do_cube(8'h88, 1'b1);
        check_res("t3", 1'b1, 1'b0, 1);
        consume("t3");

        // Same cubes, vec 0010 matches neither
        do_start(4'b0010, 1'b1, 1'b0);
        do_cube(8'h01, 1'b0);
        do_cube(8'h88, 1'b1);
        check_res("t4", 1'b0, 1'b0, 0);
        consume("t4");

        // Empty cover: constant 0 even with ON polarity, nothing consumed
        do_start(4'b1111, 1'b1, 1'b1);
        check_res("t5", 1'b0, 1'b0, 0);
        cube_valid = 1'b1;
        cube_data  = 8'h00;
        cube_last  = 1'b1;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            chk("t5_cube_ready_low", 32'(cube_ready), 32'd0);
            chk("t5_value_held",     32'(res_value),  32'd0);
        end
        cube_valid = 1'b0;
        cube_last  = 1'b0;
        consume("t5");

        // Void literal in the only cube -> err, value 0
        do_start(4'b1111, 1'b1, 1'b0);
        do_cube(8'h0C, 1'b1);
        check_res("t6", 1'b0, 1'b1, 0);
        consume("t6");

        // Void cube then all-dc cube -> value 1, err sticky
        do_start(4'b1111, 1'b1, 1'b0);
        do_cube(8'h0C, 1'b0);
        chk("t7_err_sticky_mid", 32'(res_err), 32'd1);
        do_cube(8'h00, 1'b1);
        check_res("t7", 1'b1, 1'b1, 1);

        // Hold result with res_ready low; start requests are ignored
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            start_valid = 1'b1;
            chk("hold_valid",       32'(res_valid),   32'd1);
            chk("hold_value",       32'(res_value),   32'd1);
            chk("hold_err",         32'(res_err),     32'd1);
            chk("hold_hits",        32'(res_hits),    eh(1));
            chk("hold_start_ready", 32'(start_ready), 32'd0);
        end
        @(negedge clk);
        start_valid = 1'b0;
        consume("t7");

        // Reset in the middle of an evaluation
        do_start(4'b1111, 1'b1, 1'b0);
        do_cube(8'h00, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("mid_rst_cube_ready",  32'(cube_ready),  32'd0);
        chk("mid_rst_res_valid",   32'(res_valid),   32'd0);
        chk("mid_rst_start_ready", 32'(start_ready), 32'd1);
        @(posedge clk);
        #1;
        chk("mid_rst_idle",  32'(start_ready), 32'd1);
        chk("mid_rst_value", 32'(res_value),   32'd0);
        chk("mid_rst_hits",  32'(res_hits),    32'd0);
        @(negedge clk);
        rst = 1'b1;

        // Fresh cover after reset: earlier matching row must not leak in
        do_start(4'b0000, 1'b1, 1'b0);
        do_cube(8'h01, 1'b1);
        check_res("t8", 1'b0, 1'b0, 0);
        consume("t8");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
